// File: rtl/flex_updown_counter.sv
// Up/down counter with programmable terminal value, synchronous clear/load,
// wrap or saturate behaviour, terminal flag/pulse and a saturating wrap-event count.
module flex_updown_counter #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int WRAP_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_up,
  input  logic                     sat_mode,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     rollover_pulse,
  output logic [WRAP_CNT_BITS-1:0] wrap_count
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0]  count_q, count_d;
  logic                     flag_q, flag_d;
  logic                     pulse_q, pulse_d;
  logic [WRAP_CNT_BITS-1:0] wrap_q, wrap_d;

  logic [NUM_CNT_BITS-1:0]  terminal;
  logic [NUM_CNT_BITS-1:0]  step_next;
  logic                     wrap_evt;

  // The wrap-event count sticks at all-ones instead of rolling over.
  function automatic logic [WRAP_CNT_BITS-1:0] sat_inc(input logic [WRAP_CNT_BITS-1:0] v);
    if (&v) return v;
    return v + WRAP_CNT_BITS'(1);
  endfunction

  function automatic logic [NUM_CNT_BITS-1:0] clamp_load(input logic [NUM_CNT_BITS-1:0] v,
                                                         input logic [NUM_CNT_BITS-1:0] r);
    if (v > r) return r;
    return v;
  endfunction

  assign terminal = count_up ? rollover_val : CNT_ONE;

  // Next value of one enabled step, assuming rollover_val is non-zero.
  always_comb begin
    step_next = count_q;
    wrap_evt  = 1'b0;
    if (count_up) begin
      if (count_q < rollover_val) begin
        step_next = count_q + CNT_ONE;
      end else if (sat_mode) begin
        step_next = rollover_val;
      end else begin
        step_next = CNT_ONE;
        wrap_evt  = 1'b1;
      end
    end else begin
      if (count_q > rollover_val) begin
        step_next = rollover_val;
      end else if (count_q > CNT_ONE) begin
        step_next = count_q - CNT_ONE;
      end else if (sat_mode) begin
        step_next = CNT_ONE;
      end else begin
        step_next = rollover_val;
        wrap_evt  = 1'b1;
      end
    end
  end

  // Priority: clear > load > count_enable > hold.
  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    wrap_d  = wrap_q;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
      wrap_d  = '0;
    end else if (load) begin
      count_d = clamp_load(load_val, rollover_val);
      flag_d  = 1'b0;
    end else if (count_enable) begin
      if (rollover_val == '0) begin
        count_d = '0;
        flag_d  = 1'b0;
      end else begin
        count_d = step_next;
        flag_d  = (step_next == terminal);
        pulse_d = (step_next == terminal) && (count_q != terminal);
        if (wrap_evt) wrap_d = sat_inc(wrap_q);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      wrap_q  <= '0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out      = count_q;
  assign rollover_flag  = flag_q;
  assign rollover_pulse = pulse_q;
  assign wrap_count     = wrap_q;

endmodule
